// File: rtl/pulse_sequencer_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pulse_sequencer_engine_if                                       |
// | Purpose  : Bus and handshake bundle for the pulse sequencer engine.        |
// |            Carries symbol-memory and table writes, start/stop requests    |
// |            and the busy/done/loop_evt status back to the requester.       |
// | Signals  : mem_we/mem_addr/mem_wdata  symbol-memory word write            |
// |            tab_we/tab_idx/tab_wdata   {level,duration} table write        |
// |            start/stop                 one-cycle run control requests      |
// |            busy/done/loop_evt         run status                          |
// | Modports : master (bus side), slave (engine side)                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface pulse_sequencer_engine_if #(
  parameter int MEM_WORDS = 8,
  parameter int SYM_BITS  = 2,
  parameter int DUR_W     = 8
);
  localparam int c_AW = $clog2(MEM_WORDS);

  logic              mem_we;
  logic [c_AW-1:0]   mem_addr;
  logic [31:0]       mem_wdata;
  logic              tab_we;
  logic [SYM_BITS-1:0] tab_idx;
  logic [DUR_W:0]    tab_wdata;
  logic              start;
  logic              stop;
  logic              busy;
  logic              done;
  logic              loop_evt;

  modport master (
    output mem_we, mem_addr, mem_wdata, tab_we, tab_idx, tab_wdata, start, stop,
    input  busy, done, loop_evt
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata, tab_we, tab_idx, tab_wdata, start, stop,
    output busy, done, loop_evt
  );
endinterface
`default_nettype wire

// File: rtl/pulse_sequencer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pulse_sequencer_engine                                          |
// | Purpose  : Symbol-driven pulse transmitter. Plays symbols from a 32-bit    |
// |            word memory; each symbol picks a {level,duration} table entry. |
// |            Supports loop count, stop, per-symbol prescaler, carrier        |
// |            modulation and gap-free back-to-back symbols.                  |
// | Ports    : clk, rst_n (sync active-low)                                    |
// |            bus_if          memory/table writes, start/stop, status        |
// |            i_cfg_*         run configuration, sampled at start            |
// |            o_pulse_out     modulated output                               |
// |            o_carrier_out   raw carrier                                    |
// |            o_cur_idx       index of the symbol currently driven           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pulse_sequencer_engine #(
  parameter int MEM_WORDS = 8,
  parameter int SYM_BITS  = 2,
  parameter int DUR_W     = 8,
  parameter int PRESC_W   = 4,
  parameter int LOOP_W    = 8,
  parameter int CARR_W    = 16,
  localparam int PCW      = $clog2(MEM_WORDS * 32 / SYM_BITS)
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  pulse_sequencer_engine_if.slave  bus_if,
  input  wire logic [PCW-1:0]      i_cfg_start_idx,
  input  wire logic [PCW-1:0]      i_cfg_end_idx,
  input  wire logic [LOOP_W-1:0]   i_cfg_loops,
  input  wire logic [PRESC_W-1:0]  i_cfg_prescaler,
  input  wire logic                i_cfg_idle_level,
  input  wire logic                i_cfg_invert,
  input  wire logic                i_cfg_carrier_en,
  input  wire logic [CARR_W-1:0]   i_cfg_carrier_half,
  output logic                     o_pulse_out,
  output logic                     o_carrier_out,
  output logic [PCW-1:0]           o_cur_idx
);
  localparam int c_SPW   = 32 / SYM_BITS;          // symbols per word
  localparam int c_SW    = $clog2(c_SPW);          // slot-in-word index width
  localparam int c_TAB   = 1 << SYM_BITS;
  // Symbol length in cycles is (dur+1) << presc; this width holds the worst case.
  localparam int c_CNT_W = DUR_W + (1 << PRESC_W);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;

  state_t               r_state;
  logic [31:0]          r_mem [MEM_WORDS];
  logic [DUR_W:0]       r_tab [c_TAB];
  logic                 r_busy, r_done, r_loop, r_valid, r_level, r_inf, r_car;
  logic [PCW-1:0]       r_cur_idx, r_nxt_idx, r_fidx, r_start, r_end;
  logic [DUR_W:0]       r_nxt_ent;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [LOOP_W-1:0]    r_pass;
  logic [PRESC_W-1:0]   r_presc;
  logic                 r_idle, r_inv, r_cen;
  logic [CARR_W-1:0]    r_half, r_ccnt;

  logic [PCW-1:0]       w_fidx;
  logic [31:0]          w_word;
  logic [4:0]           w_off;
  logic [SYM_BITS-1:0]  w_sym;
  logic [DUR_W:0]       w_ent;
  logic [c_CNT_W-1:0]   w_nxt_len;
  logic                 w_abort, w_last, w_pass_end, w_fin, w_adv;

  function automatic logic [PCW-1:0] f_next(input logic [PCW-1:0] idx,
                                            input logic [PCW-1:0] st,
                                            input logic [PCW-1:0] en);
    return (idx == en) ? st : idx + PCW'(1);
  endfunction

  // Symbol memory has no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (bus_if.mem_we) r_mem[bus_if.mem_addr] <= bus_if.mem_wdata;
  end

  // Single fetch port. In IDLE it points at the configured start so the first
  // symbol is captured at the start edge; afterwards it walks one symbol ahead
  // of the prefetch register. Combinational read means a same-cycle write
  // is seen only by later fetches.
  assign w_fidx    = (r_state == S_IDLE) ? i_cfg_start_idx : r_fidx;
  assign w_word    = r_mem[w_fidx[PCW-1:c_SW]];
  assign w_off     = 5'(w_fidx[c_SW-1:0] * SYM_BITS);
  assign w_sym     = w_word[w_off +: SYM_BITS];
  assign w_ent     = r_tab[w_sym];
  assign w_nxt_len = ((c_CNT_W'(r_nxt_ent[DUR_W-1:0]) + c_CNT_W'(1)) << r_presc)
                     - c_CNT_W'(1);

  assign w_abort    = (r_state != S_IDLE) && bus_if.stop;
  assign w_last     = (r_state == S_RUN) && (r_cnt == '0) && !bus_if.stop;
  assign w_pass_end = w_last && (r_cur_idx == r_end);
  assign w_fin      = w_pass_end && !r_inf && (r_pass == LOOP_W'(1));
  // Move the prefetched symbol into the output stage.
  assign w_adv      = ((r_state == S_LOAD) && !bus_if.stop) || (w_last && !w_fin);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_loop    <= 1'b0;
      r_valid   <= 1'b0;
      r_level   <= 1'b0;
      r_inf     <= 1'b0;
      r_car     <= 1'b0;
      r_cur_idx <= '0;
      r_nxt_idx <= '0;
      r_fidx    <= '0;
      r_start   <= '0;
      r_end     <= '0;
      r_nxt_ent <= '0;
      r_cnt     <= '0;
      r_pass    <= '0;
      r_presc   <= '0;
      r_idle    <= 1'b0;
      r_inv     <= 1'b0;
      r_cen     <= 1'b0;
      r_half    <= '0;
      r_ccnt    <= '0;
      for (int i = 0; i < c_TAB; i++) r_tab[i] <= '0;
    end else begin
      r_done <= w_fin;
      r_loop <= w_pass_end;

      if (bus_if.tab_we) r_tab[bus_if.tab_idx] <= bus_if.tab_wdata;

      // Carrier restarts from zero on every run.
      if ((r_state == S_IDLE) || w_abort || w_fin) begin
        r_ccnt <= '0;
        r_car  <= 1'b0;
      end else if (r_ccnt == '0) begin
        r_ccnt <= r_half;
        r_car  <= ~r_car;
      end else begin
        r_ccnt <= r_ccnt - CARR_W'(1);
      end

      if (w_adv) begin
        r_valid   <= 1'b1;
        r_level   <= r_nxt_ent[DUR_W];
        r_cnt     <= w_nxt_len;
        r_cur_idx <= r_nxt_idx;
        r_nxt_idx <= r_fidx;
        r_nxt_ent <= w_ent;
        r_fidx    <= f_next(r_fidx, r_start, r_end);
      end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end

      if (w_pass_end && !w_fin && !r_inf) r_pass <= r_pass - LOOP_W'(1);

      case (r_state)
        S_IDLE: begin
          r_idle <= i_cfg_idle_level;
          r_inv  <= i_cfg_invert;
          if (bus_if.start && !bus_if.stop) begin
            r_state   <= S_LOAD;
            r_busy    <= 1'b1;
            r_start   <= i_cfg_start_idx;
            r_end     <= i_cfg_end_idx;
            r_presc   <= i_cfg_prescaler;
            r_cen     <= i_cfg_carrier_en;
            r_half    <= i_cfg_carrier_half;
            r_pass    <= i_cfg_loops;
            r_inf     <= (i_cfg_loops == '0);
            r_nxt_idx <= i_cfg_start_idx;
            r_nxt_ent <= w_ent;
            r_fidx    <= f_next(i_cfg_start_idx, i_cfg_start_idx, i_cfg_end_idx);
          end
        end
        S_LOAD:  r_state <= S_RUN;
        S_RUN:   r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase

      if (w_abort || w_fin) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
      end
    end
  end

  assign bus_if.busy     = r_busy;
  assign bus_if.done     = r_done;
  assign bus_if.loop_evt = r_loop;
  assign o_carrier_out   = r_car;
  assign o_cur_idx       = r_cur_idx;
  assign o_pulse_out     = (r_valid ? (r_level & (r_cen ? r_car : 1'b1)) : r_idle) ^ r_inv;
endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pulse_sequencer_engine                                       |
// | Purpose  : Self-checking bench for pulse_sequencer_engine. A sequence-     |
// |            level model expands (memory, table, config) into the expected  |
// |            per-cycle outputs and compares them with the DUT.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pulse_sequencer_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  cfg_start, cfg_end;
  logic [7:0]  cfg_loops;
  logic [3:0]  cfg_presc;
  logic        cfg_idle, cfg_inv, cfg_cen;
  logic [15:0] cfg_half;
  logic        pulse_out, carrier_out;
  logic [6:0]  cur_idx;

  int          n_checks = 0;
  int          n_errors = 0;
  bit [31:0]   m_mem [8];
  bit [8:0]    m_tab [4];

  always #5 clk = ~clk;

  pulse_sequencer_engine_if bus ();

  pulse_sequencer_engine u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus_if             (bus),
    .i_cfg_start_idx    (cfg_start),
    .i_cfg_end_idx      (cfg_end),
    .i_cfg_loops        (cfg_loops),
    .i_cfg_prescaler    (cfg_presc),
    .i_cfg_idle_level   (cfg_idle),
    .i_cfg_invert       (cfg_inv),
    .i_cfg_carrier_en   (cfg_cen),
    .i_cfg_carrier_half (cfg_half),
    .o_pulse_out        (pulse_out),
    .o_carrier_out      (carrier_out),
    .o_cur_idx          (cur_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic write_mem(input int a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_we = 1'b1; bus.mem_addr = 3'(a); bus.mem_wdata = d;
    @(negedge clk);
    bus.mem_we = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic write_tab(input int i, input logic [8:0] d);
    @(negedge clk);
    bus.tab_we = 1'b1; bus.tab_idx = 2'(i); bus.tab_wdata = d;
    @(negedge clk);
    bus.tab_we = 1'b0;
    m_tab[i] = d;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"},    32'(bus.busy), 0);
    check_eq({tag, "_pulse"},   32'(pulse_out), 32'(cfg_idle ^ cfg_inv));
    check_eq({tag, "_carrier"}, 32'(carrier_out), 0);
  endtask

  // Plays one sequence against the model. stop_at: busy-cycle number at which
  // stop is pulsed (-1 none). poke_at: busy-cycle number at which a stray start
  // is pulsed (-1 none); it must have no effect.
  task automatic run_seq(input int stop_at, input int poke_at);
    int k, idx, len, sym, left;
    bit lvl, car, evt;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; k = 1;
    check_eq("load_busy",    32'(bus.busy), 1);
    check_eq("load_pulse",   32'(pulse_out), 32'(cfg_idle ^ cfg_inv));
    check_eq("load_carrier", 32'(carrier_out), 0);
    idx  = int'(cfg_start);
    left = int'(cfg_loops);
    evt  = 1'b0;
    forever begin
      sym = int'((m_mem[idx / 16] >> ((idx % 16) * 2)) & 32'h3);
      lvl = m_tab[sym][8];
      len = (int'(m_tab[sym][7:0]) + 1) << cfg_presc;
      for (int c = 0; c < len; c++) begin
        @(negedge clk); bus.start = 1'b0; k++;
        car = (((k - 2) / (int'(cfg_half) + 1)) % 2) == 0;
        check_eq("busy",     32'(bus.busy), 1);
        check_eq("cur_idx",  32'(cur_idx), 32'(idx));
        check_eq("pulse",    32'(pulse_out), 32'((lvl & (cfg_cen ? car : 1'b1)) ^ cfg_inv));
        check_eq("carrier",  32'(carrier_out), 32'(car));
        check_eq("loop_evt", 32'(bus.loop_evt), 32'(evt && (c == 0)));
        check_eq("done",     32'(bus.done), 0);
        if (k == stop_at) begin
          bus.stop = 1'b1;
          @(negedge clk); bus.stop = 1'b0;
          check_idle("stop");
          check_eq("stop_done", 32'(bus.done), 0);
          check_eq("stop_loop", 32'(bus.loop_evt), 0);
          repeat (3) begin
            @(negedge clk);
            check_eq("post_stop_done", 32'(bus.done), 0);
            check_eq("post_stop_busy", 32'(bus.busy), 0);
          end
          return;
        end
        bus.start = (k == poke_at);
      end
      evt = (idx == int'(cfg_end));
      if (evt && cfg_loops != 0) begin
        left--;
        if (left == 0) break;
      end
      idx = evt ? int'(cfg_start) : (idx + 1) % 128;
    end
    @(negedge clk); bus.start = 1'b0;
    check_eq("fin_done", 32'(bus.done), 1);
    check_eq("fin_loop", 32'(bus.loop_evt), 1);
    check_idle("fin");
    @(negedge clk);
    check_eq("after_done", 32'(bus.done), 0);
    check_eq("after_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.mem_we = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    bus.tab_we = 0; bus.tab_idx = 0; bus.tab_wdata = 0;
    bus.start = 0; bus.stop = 0;
    cfg_start = 0; cfg_end = 3; cfg_loops = 1; cfg_presc = 0;
    cfg_idle = 1; cfg_inv = 0; cfg_cen = 0; cfg_half = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",    32'(bus.busy), 0);
    check_eq("rst_done",    32'(bus.done), 0);
    check_eq("rst_loop",    32'(bus.loop_evt), 0);
    check_eq("rst_pulse",   32'(pulse_out), 0);
    check_eq("rst_carrier", 32'(carrier_out), 0);
    check_eq("rst_cur_idx", 32'(cur_idx), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) write_mem(i, 32'h0);
    write_tab(0, 9'h002); write_tab(1, 9'h000);
    write_tab(2, 9'h103); write_tab(3, 9'h100);
    write_mem(0, 32'h000000E4);

    // Basic pass, then with a prescaler.
    run_seq(-1, -1);
    cfg_presc = 2;
    run_seq(-1, -1);

    // Wrapping range, three passes, stray start mid-run.
    cfg_presc = 0; cfg_loops = 3; cfg_start = 14; cfg_end = 1;
    write_mem(0, 32'hB40000E4);
    run_seq(-1, 5);

    // Infinite looping aborted by stop.
    cfg_loops = 0; cfg_start = 0; cfg_end = 3;
    run_seq(40, -1);

    // Simultaneous start and stop from IDLE.
    @(negedge clk); bus.start = 1; bus.stop = 1;
    @(negedge clk); bus.start = 0; bus.stop = 0;
    check_eq("startstop_busy", 32'(bus.busy), 0);
    @(negedge clk);
    check_eq("startstop_busy2", 32'(bus.busy), 0);

    // Carrier modulation with inverted idle.
    cfg_loops = 1; cfg_cen = 1; cfg_half = 1; cfg_inv = 1; cfg_idle = 0;
    repeat (2) @(negedge clk);
    check_eq("inv_idle_pulse", 32'(pulse_out), 1);
    run_seq(-1, -1);

    // Reset in the middle of a run clears the table.
    cfg_cen = 0; cfg_inv = 0; cfg_loops = 2;
    @(negedge clk); bus.start = 1;
    @(negedge clk); bus.start = 0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy",  32'(bus.busy), 0);
    check_eq("midrst_pulse", 32'(pulse_out), 0);
    check_eq("midrst_car",   32'(carrier_out), 0);
    check_eq("midrst_idx",   32'(cur_idx), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_tab[i] = 9'h0;
    @(negedge clk);
    check_eq("midrst_done", 32'(bus.done), 0);
    cfg_start = 5; cfg_end = 9; cfg_presc = 1;
    run_seq(-1, -1);

    // Randomized runs.
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 8; i++) write_mem(i, $urandom);
      for (int i = 0; i < 4; i++) write_tab(i, {1'($urandom), 8'($urandom_range(0, 3))});
      cfg_start = 7'($urandom_range(0, 127));
      cfg_end   = 7'((int'(cfg_start) + $urandom_range(0, 6)) % 128);
      cfg_presc = 4'($urandom_range(0, 2));
      cfg_half  = 16'($urandom_range(0, 3));
      cfg_cen   = 1'($urandom); cfg_inv = 1'($urandom); cfg_idle = 1'($urandom);
      @(negedge clk);
      if ((r % 4) == 3) begin
        cfg_loops = 0;
        run_seq($urandom_range(5, 60), -1);
      end else begin
        cfg_loops = 8'($urandom_range(1, 3));
        run_seq(-1, $urandom_range(2, 20));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
